pc_reg: RTL and testbench

PC_REG -- requirements
Module: pc_reg

---
 rtl/pc_reg_if.sv | 25 ++
 rtl/pc_reg.sv | 53 +++++
 tb/tb_pc_reg.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pc_reg_if.sv
// rtl/pc_reg_if.sv - command and status bundle between a sequencer and pc_reg
interface pc_reg_if #(
    parameter int WIDTH = 12
);
    logic             ld;
    logic             call;
    logic             ret;
    logic             skip;
    logic             inc;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] lr;
    logic             wrap;

    modport master (
        output ld, call, ret, skip, inc, din,
        input  q, nq, lr, wrap
    );

    modport slave (
        input  ld, call, ret, skip, inc, din,
        output q, nq, lr, wrap
    );
endinterface

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with link register, skip/inc and wrap pulse
module pc_reg #(
    parameter int               WIDTH     = 12,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic    clk,
    input  logic    clr,
    pc_reg_if.slave bus
);
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] lr_r;
    logic             wrap_r;

    // One extra bit on the sums so the carry out of the top becomes the wrap flag.
    logic [WIDTH:0] q_plus1;
    logic [WIDTH:0] q_plus2;

    assign q_plus1 = {1'b0, q_r} + {{WIDTH{1'b0}}, 1'b1};
    assign q_plus2 = {1'b0, q_r} + {{(WIDTH-1){1'b0}}, 2'b10};

    // Single-winner command decode: clr > call > ret > ld > skip > inc > hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_r    <= RESET_VAL;
            lr_r   <= '0;
            wrap_r <= 1'b0;
        end else if (bus.call) begin
            q_r    <= bus.din;
            lr_r   <= q_plus1[WIDTH-1:0];
            wrap_r <= 1'b0;
        end else if (bus.ret) begin
            q_r    <= lr_r;
            wrap_r <= 1'b0;
        end else if (bus.ld) begin
            q_r    <= bus.din;
            wrap_r <= 1'b0;
        end else if (bus.skip) begin
            q_r    <= q_plus2[WIDTH-1:0];
            wrap_r <= q_plus2[WIDTH];
        end else if (bus.inc) begin
            q_r    <= q_plus1[WIDTH-1:0];
            wrap_r <= q_plus1[WIDTH];
        end else begin
            wrap_r <= 1'b0;
        end
    end

    // The lamp driver side wants the inverted pc; it is derived, not stored.
    assign bus.q    = q_r;
    assign bus.nq   = ~q_r;
    assign bus.lr   = lr_r;
    assign bus.wrap = wrap_r;
endmodule

// File: tb/tb_pc_reg.sv
// tb/tb_pc_reg.sv - directed and randomized checks of pc_reg at WIDTH 12 and 4
module tb_pc_reg;
    localparam logic [5:0] C_HOLD = 6'b000000;
    localparam logic [5:0] C_INC  = 6'b000001;
    localparam logic [5:0] C_SKIP = 6'b000010;
    localparam logic [5:0] C_LD   = 6'b000100;
    localparam logic [5:0] C_RET  = 6'b001000;
    localparam logic [5:0] C_CALL = 6'b010000;
    localparam logic [5:0] C_CLR  = 6'b100000;
    localparam int         RV4    = 10;

    logic clk = 1'b0;
    logic clr;

    int n_assert = 0;
    int n_fail   = 0;

    int q12, lr12, w12;
    int q4, lr4, w4;

    pc_reg_if #(.WIDTH(12)) a12 ();
    pc_reg_if #(.WIDTH(4))  a4  ();

    pc_reg #(.WIDTH(12)) u12 (.clk(clk), .clr(clr), .bus(a12));
    pc_reg #(.WIDTH(4), .RESET_VAL(4'(RV4))) u4 (.clk(clk), .clr(clr), .bus(a4));

    always #5 clk = ~clk;

    task automatic model_step(input int w, input int rv, input logic [5:0] c, input int d,
                              inout int mq, inout int mlr, inout int mw);
        int m;
        m = 1 << w;
        if (c[5]) begin
            mq = rv; mlr = 0; mw = 0;
        end else if (c[4]) begin
            mlr = (mq + 1) % m; mq = d % m; mw = 0;
        end else if (c[3]) begin
            mq = mlr; mw = 0;
        end else if (c[2]) begin
            mq = d % m; mw = 0;
        end else if (c[1]) begin
            mw = (mq + 2 >= m) ? 1 : 0; mq = (mq + 2) % m;
        end else if (c[0]) begin
            mw = (mq + 1 >= m) ? 1 : 0; mq = (mq + 1) % m;
        end else begin
            mw = 0;
        end
    endtask

    task automatic cycle(input logic [5:0] c, input logic [11:0] d);
        @(negedge clk);
        clr = c[5];
        a12.call = c[4]; a12.ret = c[3]; a12.ld = c[2]; a12.skip = c[1]; a12.inc = c[0];
        a4.call  = c[4]; a4.ret  = c[3]; a4.ld  = c[2]; a4.skip  = c[1]; a4.inc  = c[0];
        a12.din = d;
        a4.din  = d[3:0];
        @(posedge clk);
        model_step(12, 0, c, int'(d), q12, lr12, w12);
        model_step(4, RV4, c, int'(d), q4, lr4, w4);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk12(input string tag, input logic [11:0] eq, input logic [11:0] elr,
                         input logic ew);
        chk({tag, ".q"}, a12.q, eq);
        chk({tag, ".nq"}, a12.nq, ~eq);
        chk({tag, ".lr"}, a12.lr, elr);
        chk({tag, ".wrap"}, {11'd0, a12.wrap}, {11'd0, ew});
    endtask

    task automatic chk_models(input string tag);
        logic [11:0] e12;
        logic [3:0]  e4;
        e12 = q12[11:0];
        e4  = q4[3:0];
        chk({tag, ".q12"}, a12.q, e12);
        chk({tag, ".nq12"}, a12.nq, ~e12);
        chk({tag, ".lr12"}, a12.lr, lr12[11:0]);
        chk({tag, ".wrap12"}, {11'd0, a12.wrap}, w12[11:0]);
        chk({tag, ".q4"}, {8'd0, a4.q}, {8'd0, e4});
        chk({tag, ".nq4"}, {8'd0, a4.nq}, {8'd0, ~e4});
        chk({tag, ".lr4"}, {8'd0, a4.lr}, lr4[11:0]);
        chk({tag, ".wrap4"}, {11'd0, a4.wrap}, w4[11:0]);
    endtask

    initial begin
        logic [5:0]  c;
        logic [11:0] d;
        q12 = 0; lr12 = 0; w12 = 0; q4 = 0; lr4 = 0; w4 = 0;

        // Reset overrides a simultaneous load
        cycle(C_CLR | C_LD, 12'h123);
        chk12("reset", 12'h000, 12'h000, 1'b0);
        chk("reset.q4", {8'd0, a4.q}, 12'(RV4));

        // First edge after reset executes normally
        cycle(C_LD, 12'h040);
        chk12("ld_after_reset", 12'h040, 12'h000, 1'b0);

        // clr raised between edges does nothing until an edge sees it
        @(negedge clk);
        clr = 1'b1;
        #2;
        chk12("clr_between_edges", 12'h040, 12'h000, 1'b0);
        clr = 1'b0;

        // inc across the top
        cycle(C_LD, 12'hFFE);
        cycle(C_INC, 12'h000);
        chk12("inc_to_fff", 12'hFFF, 12'h000, 1'b0);
        cycle(C_INC, 12'h000);
        chk12("inc_wrap", 12'h000, 12'h000, 1'b1);
        cycle(C_HOLD, 12'h000);
        chk12("hold_after_wrap", 12'h000, 12'h000, 1'b0);

        // skip across the top and in the middle
        cycle(C_LD, 12'hFFF);
        cycle(C_SKIP, 12'h000);
        chk12("skip_wrap_fff", 12'h001, 12'h000, 1'b1);
        cycle(C_LD, 12'hFFE);
        cycle(C_SKIP, 12'h000);
        chk12("skip_wrap_ffe", 12'h000, 12'h000, 1'b1);
        cycle(C_LD, 12'h010);
        cycle(C_SKIP, 12'h000);
        chk12("skip_mid", 12'h012, 12'h000, 1'b0);

        // call, run a little, return
        cycle(C_LD, 12'h040);
        cycle(C_CALL, 12'h200);
        chk12("call", 12'h200, 12'h041, 1'b0);
        cycle(C_INC, 12'h000);
        cycle(C_INC, 12'h000);
        cycle(C_INC, 12'h000);
        chk12("inc_x3", 12'h203, 12'h041, 1'b0);
        cycle(C_RET, 12'h000);
        chk12("ret", 12'h041, 12'h041, 1'b0);

        // call to itself still updates lr
        cycle(C_LD, 12'h123);
        cycle(C_CALL, 12'h123);
        chk12("call_self", 12'h123, 12'h124, 1'b0);

        // all commands at once: call wins; then clr wins over everything
        cycle(C_LD, 12'h010);
        cycle(C_CALL | C_RET | C_LD | C_SKIP | C_INC, 12'h555);
        chk12("all_cmds", 12'h555, 12'h011, 1'b0);
        cycle(C_LD, 12'h010);
        cycle(C_CLR | C_CALL | C_RET | C_LD | C_SKIP | C_INC, 12'h555);
        chk12("all_cmds_clr", 12'h000, 12'h000, 1'b0);

        // reset between call and ret discards the link
        cycle(C_LD, 12'h300);
        cycle(C_CALL, 12'h400);
        chk12("call2", 12'h400, 12'h301, 1'b0);
        cycle(C_CLR, 12'h000);
        cycle(C_RET, 12'h000);
        chk12("ret_after_clr", 12'h000, 12'h000, 1'b0);

        // ld versus ret priority: ret wins
        cycle(C_CALL, 12'h0AB);
        cycle(C_RET | C_LD, 12'h777);
        chk12("ret_over_ld", 12'h001, 12'h001, 1'b0);

        // Randomized command streams for both widths against the model
        chk_models("pre_random");
        for (int i = 0; i < 600; i++) begin
            c = 6'(($urandom & 32'h1F) & ($urandom & 32'h1F) & ($urandom & 32'h1F));
            if ($urandom_range(0, 3) == 0) c = C_INC;
            if ($urandom_range(0, 5) == 0) c = C_SKIP;
            if ($urandom_range(0, 40) == 0) c[5] = 1'b1;
            d = 12'($urandom);
            if ($urandom_range(0, 3) == 0) d = 12'hFFD | 12'($urandom_range(0, 2));
            cycle(c, d);
            chk_models("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
